mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported synchronous memory between the CPU's instruction-fetch port and its load/store port. Sits between `cpu` (fetch and ldst request ports) and the memory. It arbitrates one access per cycle, returns read data to the correct requester one cycle later, and stalls the losing requester. Load/store has priority, and a bounded-run counter guarantees that fetch cannot starve.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (byte enables are `DW/8`)
- `MAX_LS_RUN`, 4, maximum consecutive load/store grants while a fetch is waiting; must be at least 1

Ports:
- `clk`  in  1  clock; one clock domain
- `reset`  in  1  synchronous, active-high
- `i_if_addr`  in  AW  fetch address
- `i_if_rd`  in  1  fetch read request
- `o_if_stall`  out  1  fetch request not accepted this cycle
- `o_if_valid`  out  1  fetch read data valid
- `o_if_rddata`  out  DW  fetch read data
- `i_ls_addr`  in  AW  load/store address
- `i_ls_rd`  in  1  load request
- `i_ls_wr`  in  1  store request
- `i_ls_wrdata`  in  DW  store data
- `i_ls_byte_en`  in  DW/8  load/store byte enables
- `o_ls_stall`  out  1  load/store request not accepted this cycle
- `o_ls_valid`  out  1  load read data valid
- `o_ls_rddata`  out  DW  load read data
- `o_mem_addr`  out  AW  memory address
- `o_mem_rd`  out  1  memory read strobe
- `o_mem_wr`  out  1  memory write strobe
- `o_mem_wrdata`  out  DW  memory write data
- `o_mem_byte_en`  out  DW/8  memory byte enables
- `i_mem_rddata`  in  DW  memory read data, valid the cycle after `o_mem_rd`

## Operation
Request acceptance:
- A request is accepted in a cycle where it is asserted and its stall is low.
- The requester holds address, data and enables stable until accepted.
- Stall is never asserted for a port with no request.

Load/store request decode:
- If `i_ls_rd` and `i_ls_wr` are both high, the request is a write and the read is ignored.

Grant rule, evaluated each cycle:
- If no load/store request: grant fetch if it is requesting.
- If no fetch request: grant load/store.
- If both are requesting: grant load/store unless `run_cnt == MAX_LS_RUN`, in which case grant fetch.

`run_cnt` (width `$clog2(MAX_LS_RUN+1)`):
- Increments on a load/store grant while fetch is requesting.
- Clears on a fetch grant, and in any cycle where fetch is not requesting.
- Saturates at `MAX_LS_RUN`.

Memory drive:
- Memory outputs are a mux of the granted port.
- Fetch grant drives `o_mem_byte_en = '1`, `o_mem_rd = 1`.
- With no grant, `o_mem_rd` and `o_mem_wr` are 0, and addr/wrdata/byte_en are 0.
- Address low bits are passed unchanged; alignment is the requester's responsibility.

Response FSM (`resp_owner`):
- States: `OWN_NONE`, `OWN_IF`, `OWN_LS`.
- The next state is set from this cycle's read grant (fetch read → `OWN_IF`; load → `OWN_LS`; write or idle → `OWN_NONE`).
- In `OWN_IF`, `o_if_valid = 1`. In `OWN_LS`, `o_ls_valid = 1`. Valid is high for exactly one cycle per accepted read.
- Writes produce no response.

Read data:
- `o_*_rddata` equals `i_mem_rddata` while that port's valid is high.
- Otherwise it holds the last value delivered to that port (per-port hold register, loaded on valid).

## Timing
- Grant, stall and memory outputs are combinational from the current requests and `run_cnt`. There is no added cycle on the request path.
- Read latency: accepted in cycle N, valid in cycle N+1. Back-to-back reads from either port are supported at one per cycle.
- Alternating owners are legal: fetch read in N and load in N+1 give `if_valid` in N+1 and `ls_valid` in N+2.
- Reset values: `resp_owner = OWN_NONE`; `run_cnt = 0`; both valids 0; both rddata hold registers 0.
- While `reset` is high, outputs follow the combinational grant rule from the current requests. Requesters must not request during reset.
- A read accepted in the cycle `reset` is asserted never produces a valid.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - `resp_owner_t` enum: `OWN_NONE`, `OWN_IF`, `OWN_LS`
  - `BE_FULL` constant
  - the grant encoding used by `cpu` and the testbench
- One natural sub-module: `mem_arb_resp`. It contains the owner register, valid generation and the two rddata hold registers. The top level contains the grant logic, `run_cnt` and the memory mux.

## Test plan
- Fetch only: read at 0x0, 0x4, 0x8 with memory returning the address plus 0x100. Expect `o_if_stall` always 0, `o_if_valid` in cycles 1–3, and rddata 0x100/0x104/0x108.
- Simultaneous fetch and load at reset: expect the load granted (`o_if_stall = 1`), `o_ls_valid` next cycle, and the fetch granted the following cycle.
- Continuous loads with fetch pending and `MAX_LS_RUN = 4`: expect 4 load grants, then 1 fetch grant, repeating. The fetch is never stalled more than 4 cycles.
- Store to 0x40 with byte_en 4'b0011 and data 0xDEADBEEF: expect `o_mem_wr = 1`, `o_mem_rd = 0` and the fields passed through, with no `o_ls_valid`. With rd and wr both set, expect the same.
- Load accepted, then `reset` asserted the next cycle: expect `o_ls_valid = 0`, rddata 0 and `run_cnt` cleared. After reset, fetch is granted immediately.
- Fetch rddata hold: after a valid with 0x1234, drive `i_mem_rddata` to other values for 3 idle cycles. Expect `o_if_rddata` to stay 0x1234.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory port: response ownership, grant encoding,
// and the full byte-enable constant used for fetch reads.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } resp_owner_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_LS   = 2'd2
   } grant_t;

   // Wide enough for any practical data width; users slice the low DW/8 bits.
   localparam int unsigned          BE_MAX_W = 128;
   localparam logic [BE_MAX_W-1:0]  BE_FULL  = '1;

   // Who owns the memory response in the cycle after a grant.
   function automatic resp_owner_t read_owner(grant_t gnt, logic ls_is_read);
      resp_owner_t owner;
      owner = OWN_NONE;
      case (gnt)
         GNT_IF:  owner = OWN_IF;
         GNT_LS:  owner = ls_is_read ? OWN_LS : OWN_NONE;
         default: owner = OWN_NONE;
      endcase
      return owner;
   endfunction

endpackage

// File: rtl/mem_arb_resp.sv
// Response side of the arbiter: tracks which port owns the returning read
// data, raises that port's valid, and keeps per-port hold registers.
module mem_arb_resp
   import cpu_mem_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    i_gnt,
   input  logic          i_ls_is_read,
   input  logic [DW-1:0] i_mem_rddata,
   output logic          o_if_valid,
   output logic [DW-1:0] o_if_rddata,
   output logic          o_ls_valid,
   output logic [DW-1:0] o_ls_rddata
);

   resp_owner_t   owner_q, owner_d;
   logic [DW-1:0] if_hold_q, ls_hold_q;

   always_comb begin
      owner_d = read_owner(grant_t'(i_gnt), i_ls_is_read);
   end

   // NOTE: the hold registers are a couple of words, so they are reset along
   // with the owner; that makes the post-reset rddata a known zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q   <= OWN_NONE;
         if_hold_q <= '0;
         ls_hold_q <= '0;
      end else begin
         owner_q <= owner_d;
         if (o_if_valid) if_hold_q <= i_mem_rddata;
         if (o_ls_valid) ls_hold_q <= i_mem_rddata;
      end
   end

   assign o_if_valid  = (owner_q == OWN_IF);
   assign o_ls_valid  = (owner_q == OWN_LS);
   assign o_if_rddata = o_if_valid ? i_mem_rddata : if_hold_q;
   assign o_ls_rddata = o_ls_valid ? i_mem_rddata : ls_hold_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Load/store wins, but a bounded run counter keeps fetch from starving.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MAX_LS_RUN = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   i_if_addr,
   input  logic            i_if_rd,
   output logic            o_if_stall,
   output logic            o_if_valid,
   output logic [DW-1:0]   o_if_rddata,
   input  logic [AW-1:0]   i_ls_addr,
   input  logic            i_ls_rd,
   input  logic            i_ls_wr,
   input  logic [DW-1:0]   i_ls_wrdata,
   input  logic [DW/8-1:0] i_ls_byte_en,
   output logic            o_ls_stall,
   output logic            o_ls_valid,
   output logic [DW-1:0]   o_ls_rddata,
   output logic [AW-1:0]   o_mem_addr,
   output logic            o_mem_rd,
   output logic            o_mem_wr,
   output logic [DW-1:0]   o_mem_wrdata,
   output logic [DW/8-1:0] o_mem_byte_en,
   input  logic [DW-1:0]   i_mem_rddata
);

   localparam int              RCW     = $clog2(MAX_LS_RUN + 1);
   localparam int              BEW     = DW / 8;
   localparam logic [RCW-1:0]  RUN_MAX = RCW'(MAX_LS_RUN);

   logic           if_req, ls_req, ls_is_read;
   grant_t         gnt;
   logic [RCW-1:0] run_cnt_q, run_cnt_d;

   // A simultaneous rd+wr is treated as a plain store.
   assign if_req     = i_if_rd;
   assign ls_req     = i_ls_rd | i_ls_wr;
   assign ls_is_read = i_ls_rd & ~i_ls_wr;

   always_comb begin
      gnt = GNT_NONE;
      if (ls_req && !(if_req && run_cnt_q == RUN_MAX)) begin
         gnt = GNT_LS;
      end else if (if_req) begin
         gnt = GNT_IF;
      end
   end

   assign o_if_stall = if_req && (gnt != GNT_IF);
   assign o_ls_stall = ls_req && (gnt != GNT_LS);

   always_comb begin
      run_cnt_d = run_cnt_q;
      if (!if_req || gnt == GNT_IF) begin
         run_cnt_d = '0;
      end else if (gnt == GNT_LS && run_cnt_q != RUN_MAX) begin
         run_cnt_d = run_cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (reset) run_cnt_q <= '0;
      else       run_cnt_q <= run_cnt_d;
   end

   always_comb begin
      o_mem_addr    = '0;
      o_mem_rd      = 1'b0;
      o_mem_wr      = 1'b0;
      o_mem_wrdata  = '0;
      o_mem_byte_en = '0;
      case (gnt)
         GNT_IF: begin
            o_mem_addr    = i_if_addr;
            o_mem_rd      = 1'b1;
            o_mem_byte_en = BE_FULL[BEW-1:0];
         end
         GNT_LS: begin
            o_mem_addr    = i_ls_addr;
            o_mem_rd      = ls_is_read;
            o_mem_wr      = i_ls_wr;
            o_mem_wrdata  = i_ls_wrdata;
            o_mem_byte_en = i_ls_byte_en;
         end
         default: ;
      endcase
   end

   mem_arb_resp #(
      .DW(DW)
   ) u_resp (
      .clk          (clk),
      .reset        (reset),
      .i_gnt        (gnt),
      .i_ls_is_read (ls_is_read),
      .i_mem_rddata (i_mem_rddata),
      .o_if_valid   (o_if_valid),
      .o_if_rddata  (o_if_rddata),
      .o_ls_valid   (o_ls_valid),
      .o_ls_rddata  (o_ls_rddata)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// of the grant rule, fetch fairness and one-cycle read responses.
module tb_mem_port_arbiter;
   import cpu_mem_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MAX_LS_RUN = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] if_addr, ls_addr;
   logic          if_rd, ls_rd, ls_wr;
   logic [DW-1:0] ls_wrdata, mem_rddata;
   logic [BW-1:0] ls_be;

   logic          o_if_stall, o_if_valid, o_ls_stall, o_ls_valid, o_mem_rd, o_mem_wr;
   logic [DW-1:0] o_if_rddata, o_ls_rddata, o_mem_wrdata;
   logic [AW-1:0] o_mem_addr;
   logic [BW-1:0] o_mem_byte_en;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LS_RUN(MAX_LS_RUN)) dut (
      .clk(clk), .reset(reset),
      .i_if_addr(if_addr), .i_if_rd(if_rd), .o_if_stall(o_if_stall),
      .o_if_valid(o_if_valid), .o_if_rddata(o_if_rddata),
      .i_ls_addr(ls_addr), .i_ls_rd(ls_rd), .i_ls_wr(ls_wr),
      .i_ls_wrdata(ls_wrdata), .i_ls_byte_en(ls_be), .o_ls_stall(o_ls_stall),
      .o_ls_valid(o_ls_valid), .o_ls_rddata(o_ls_rddata),
      .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
      .o_mem_wrdata(o_mem_wrdata), .o_mem_byte_en(o_mem_byte_en),
      .i_mem_rddata(mem_rddata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: consecutive load/store wins over a waiting fetch, who gets
   // next cycle's read data, and what each port last received.
   int            ls_streak;
   int            if_wait;
   resp_owner_t   exp_owner;
   logic [AW-1:0] resp_addr;
   logic [DW-1:0] exp_if_hold, exp_ls_hold;
   bit            acc_if, acc_ls;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      return a + 32'h100;
   endfunction

   // One clock cycle: drive memory data, compare all outputs, advance model.
   task automatic cycle();
      grant_t        g;
      logic [DW-1:0] rd_val;
      bit            if_req, ls_req, ls_read;
      if_req  = if_rd;
      ls_req  = ls_rd || ls_wr;
      ls_read = ls_rd && !ls_wr;
      if (ls_req && !(if_req && ls_streak >= MAX_LS_RUN)) g = GNT_LS;
      else if (if_req)                                     g = GNT_IF;
      else                                                 g = GNT_NONE;
      rd_val = (exp_owner != OWN_NONE) ? mem_fn(resp_addr) : DW'($urandom);
      mem_rddata = rd_val;
      #2;
      check("if_stall", o_if_stall, if_req && g != GNT_IF);
      check("ls_stall", o_ls_stall, ls_req && g != GNT_LS);
      check("mem_rd", o_mem_rd, g == GNT_IF || (g == GNT_LS && ls_read));
      check("mem_wr", o_mem_wr, g == GNT_LS && ls_wr);
      check("mem_addr", o_mem_addr, (g == GNT_IF) ? if_addr : (g == GNT_LS) ? ls_addr : '0);
      check("mem_wrdata", o_mem_wrdata, (g == GNT_LS) ? ls_wrdata : '0);
      check("mem_be", o_mem_byte_en, (g == GNT_IF) ? {BW{1'b1}} : (g == GNT_LS) ? ls_be : '0);
      check("if_valid", o_if_valid, exp_owner == OWN_IF);
      check("ls_valid", o_ls_valid, exp_owner == OWN_LS);
      check("if_rddata", o_if_rddata, (exp_owner == OWN_IF) ? rd_val : exp_if_hold);
      check("ls_rddata", o_ls_rddata, (exp_owner == OWN_LS) ? rd_val : exp_ls_hold);
      if (if_req && g != GNT_IF) if_wait++;
      else                       if_wait = 0;
      check("if_starve", if_wait <= MAX_LS_RUN, 1'b1);
      @(posedge clk);
      if (exp_owner == OWN_IF) exp_if_hold = rd_val;
      if (exp_owner == OWN_LS) exp_ls_hold = rd_val;
      if (!if_req || g == GNT_IF)                      ls_streak = 0;
      else if (g == GNT_LS && ls_streak < MAX_LS_RUN)  ls_streak++;
      if (g == GNT_IF)                 exp_owner = OWN_IF;
      else if (g == GNT_LS && ls_read) exp_owner = OWN_LS;
      else                             exp_owner = OWN_NONE;
      resp_addr = (g == GNT_IF) ? if_addr : ls_addr;
      if (reset) begin
         ls_streak   = 0;
         exp_owner   = OWN_NONE;
         exp_if_hold = '0;
         exp_ls_hold = '0;
      end
      acc_if = if_req && g == GNT_IF;
      acc_ls = ls_req && g == GNT_LS;
      #1;
   endtask

   task automatic idle_ls();
      ls_rd = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_wrdata = '0; ls_be = '0;
   endtask

   initial begin
      int run;
      reset = 1'b1; if_rd = 1'b0; if_addr = '0; mem_rddata = '0;
      idle_ls();
      ls_streak = 0; if_wait = 0; exp_owner = OWN_NONE;
      resp_addr = '0; exp_if_hold = '0; exp_ls_hold = '0;
      repeat (2) @(posedge clk);
      #1;
      cycle();
      reset = 1'b0;

      // Fetch only: 0x0, 0x4, 0x8 back to back.
      for (int i = 0; i < 3; i++) begin
         if_rd = 1'b1; if_addr = AW'(i * 4);
         cycle();
      end
      if_rd = 1'b0;
      cycle();
      cycle();
      check("fetch_last_data", o_if_rddata, 32'h108);

      // Simultaneous fetch and load: load first, fetch the next cycle.
      if_rd = 1'b1; if_addr = 32'h200;
      ls_rd = 1'b1; ls_addr = 32'h300; ls_be = '1;
      cycle();
      idle_ls();
      cycle();
      if_rd = 1'b0;
      cycle();

      // Continuous loads with a fetch always pending: runs of MAX_LS_RUN.
      if_rd = 1'b1; if_addr = 32'h400; ls_rd = 1'b1; ls_be = '1;
      run = 0;
      for (int i = 0; i < 20; i++) begin
         ls_addr = 32'h800 + AW'(i * 4);
         cycle();
         if (acc_ls) run++;
         if (acc_if) begin
            check("ls_run_len", run, MAX_LS_RUN);
            run = 0;
            if_addr = if_addr + 4;
         end
      end
      if_rd = 1'b0; idle_ls();
      cycle();

      // Store, then store with rd also set; neither responds.
      ls_wr = 1'b1; ls_addr = 32'h40; ls_be = 4'b0011; ls_wrdata = 32'hDEADBEEF;
      cycle();
      ls_rd = 1'b1;
      cycle();
      idle_ls();
      cycle();

      // Build up a load run, then reset with a load response in flight.
      if_rd = 1'b1; if_addr = 32'h500; ls_rd = 1'b1; ls_addr = 32'h900; ls_be = '1;
      repeat (3) cycle();
      if_rd = 1'b0; idle_ls(); reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_ls_valid", o_ls_valid, 1'b0);
      check("rst_ls_rddata", o_ls_rddata, '0);
      if_rd = 1'b1; if_addr = 32'h600;
      cycle();
      check("fetch_after_rst", o_if_valid, 1'b1);
      ls_rd = 1'b1; ls_addr = 32'hA00; ls_be = '1;
      repeat (6) cycle();
      if_rd = 1'b0; idle_ls();
      cycle();

      // A read accepted while reset is high never responds.
      reset = 1'b1; ls_rd = 1'b1; ls_addr = 32'hB00; ls_be = '1;
      cycle();
      reset = 1'b0; idle_ls();
      cycle();

      // Fetch rddata hold across idle cycles with garbage on the bus.
      if_rd = 1'b1; if_addr = 32'h1134;
      cycle();
      if_rd = 1'b0;
      repeat (4) cycle();
      check("if_hold", o_if_rddata, 32'h1234);

      // Random traffic; each requester holds its request until accepted.
      for (int i = 0; i < 500; i++) begin
         if (!if_rd || acc_if) begin
            if_rd   = ($urandom_range(0, 3) != 0);
            if_addr = $urandom & ~32'd3;
         end
         if (!(ls_rd || ls_wr) || acc_ls) begin
            int r;
            r = int'($urandom_range(0, 7));
            ls_rd     = (r >= 1 && r <= 4) || r == 6;
            ls_wr     = (r == 5) || (r == 6);
            ls_addr   = $urandom & ~32'd3;
            ls_wrdata = $urandom;
            ls_be     = BW'($urandom);
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
